// File: rtl/vga_embarcacao_param.sv
// Parametrised NCELL-cell ship renderer with shot handshake, sunk flag and blinking hits.
// Optional white cell outline when VGA_CONTORNO_EN is defined.
module vga_embarcacao_param #(
  parameter int NCELL      = 2,
  parameter int GRID       = 8,
  parameter int X0         = 16,
  parameter int Y0         = 16,
  parameter int PITCH_X    = 62,
  parameter int PITCH_Y    = 57,
  parameter int CELL_W     = 54,
  parameter int CELL_H     = 49,
  parameter int BLINK_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               areaAtiva,
  input  logic [9:0]         coluna,
  input  logic [9:0]         linha,
  input  logic               carregar,
  input  logic [8*NCELL-1:0] posicoesEmbarcacao,
  input  logic               tiro_valido,
  input  logic [3:0]         tiro_x,
  input  logic [3:0]         tiro_y,
  output logic               tiro_ack,
  output logic               acerto,
  output logic               afundado,
  output logic               rgb_r,
  output logic               rgb_g,
  output logic               rgb_b
);

  // state | meaning
  // IDLE  | waiting for a shot request
  // CHECK | latched shot compared against enabled cells
  // RESP  | tiro_ack pulse, hit bits updated
  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

  localparam logic [3:0] GRID_W = 4'(GRID);
  localparam logic [9:0] X0_W   = 10'(X0);
  localparam logic [9:0] Y0_W   = 10'(Y0);
  localparam logic [9:0] PX_W   = 10'(PITCH_X);
  localparam logic [9:0] PY_W   = 10'(PITCH_Y);
  localparam logic [9:0] CW_W   = 10'(CELL_W);
  localparam logic [9:0] CH_W   = 10'(CELL_H);
  localparam logic [BLINK_LOG2-1:0] FRAME_ONE = {{(BLINK_LOG2-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [8*NCELL-1:0]   pos_q;
  logic [NCELL-1:0]     en_c, en_q, match_c, match_q, match_d, hit_q, hit_d;
  logic [NCELL-1:0]     inside_c, border_c;
  logic [9:0]           left_c [NCELL];
  logic [9:0]           down_c [NCELL];
  logic [9:0]           left_q [NCELL];
  logic [9:0]           down_q [NCELL];
  logic [3:0]           shot_x_q, shot_x_d, shot_y_q, shot_y_d;
  logic                 afundado_q, afundado_d;
  logic [BLINK_LOG2-1:0] frame_q;
  logic                 blink;
  logic [2:0]           rgb_q, rgb_d;

  for (genvar g = 0; g < NCELL; g++) begin : g_cell
    logic [3:0] cx, cy;
    assign cx = pos_q[8*g +: 4];
    assign cy = pos_q[8*g+4 +: 4];
    assign en_c[g]    = (cx != 4'd0) && (cx <= GRID_W) && (cy != 4'd0) && (cy <= GRID_W);
    assign left_c[g]  = X0_W + (10'(cx) - 10'd1) * PX_W;
    assign down_c[g]  = Y0_W + (10'(cy) - 10'd1) * PY_W;
    assign match_c[g] = en_c[g] && (cx == shot_x_q) && (cy == shot_y_q);
    assign inside_c[g] = en_q[g] &&
                         (coluna > left_q[g]) && (coluna < left_q[g] + CW_W) &&
                         (linha  > down_q[g]) && (linha  < down_q[g] + CH_W);
`ifdef VGA_CONTORNO_EN
    logic col_in, lin_in;
    assign col_in = (coluna >= left_q[g]) && (coluna <= left_q[g] + CW_W);
    assign lin_in = (linha  >= down_q[g]) && (linha  <= down_q[g] + CH_W);
    assign border_c[g] = en_q[g] &&
        ((((coluna == left_q[g]) || (coluna == left_q[g] + CW_W)) && lin_in) ||
         (((linha  == down_q[g]) || (linha  == down_q[g] + CH_W)) && col_in));
`else
    assign border_c[g] = 1'b0;
`endif
  end

  // Load has priority: it aborts any shot in flight and clears the hit mask.
  always_comb begin
    state_d  = state_q;
    shot_x_d = shot_x_q;
    shot_y_d = shot_y_q;
    match_d  = match_q;
    hit_d    = hit_q;
    tiro_ack = 1'b0;
    acerto   = 1'b0;
    case (state_q)
      IDLE: begin
        if (tiro_valido) begin
          shot_x_d = tiro_x;
          shot_y_d = tiro_y;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        match_d = match_c;
        state_d = RESP;
      end
      RESP: begin
        tiro_ack = 1'b1;
        acerto   = |match_q;
        hit_d    = hit_q | match_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (carregar) begin
      state_d  = IDLE;
      hit_d    = '0;
      tiro_ack = 1'b0;
      acerto   = 1'b0;
    end
  end

  assign afundado_d = (|en_c) && ((hit_d & en_c) == en_c);
  assign blink      = frame_q[BLINK_LOG2-1];

  always_comb begin
    rgb_d = 3'b000;
    if (areaAtiva) begin
      if (|inside_c) begin
        if (afundado_q)                 rgb_d = 3'b100;
        else if (|(inside_c & hit_q))   rgb_d = blink ? 3'b100 : 3'b000;
        else                            rgb_d = 3'b001;
      end else if (|border_c) begin
        rgb_d = 3'b111;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pos_q      <= '0;
      en_q       <= '0;
      hit_q      <= '0;
      match_q    <= '0;
      shot_x_q   <= '0;
      shot_y_q   <= '0;
      afundado_q <= 1'b0;
      frame_q    <= '0;
      rgb_q      <= '0;
      for (int i = 0; i < NCELL; i++) begin
        left_q[i] <= '0;
        down_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      if (carregar) pos_q <= posicoesEmbarcacao;
      en_q       <= en_c;
      hit_q      <= hit_d;
      match_q    <= match_d;
      shot_x_q   <= shot_x_d;
      shot_y_q   <= shot_y_d;
      afundado_q <= afundado_d;
      if ((coluna == 10'd0) && (linha == 10'd0)) frame_q <= frame_q + FRAME_ONE;
      rgb_q      <= rgb_d;
      for (int i = 0; i < NCELL; i++) begin
        left_q[i] <= left_c[i];
        down_q[i] <= down_c[i];
      end
    end
  end

  assign afundado = afundado_q;
  assign {rgb_r, rgb_g, rgb_b} = rgb_q;

endmodule

// File: tb/tb_vga_embarcacao_param.sv
// Directed bench for vga_embarcacao_param: pixel vector table plus shot/load/reset sequences.
module tb_vga_embarcacao_param;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        areaAtiva = 1'b1;
  logic [9:0]  coluna = 10'd300;
  logic [9:0]  linha = 10'd300;
  logic        carregar = 1'b0;
  logic [15:0] posicoesEmbarcacao = 16'h0000;
  logic        tiro_valido = 1'b0;
  logic [3:0]  tiro_x = 4'd0;
  logic [3:0]  tiro_y = 4'd0;
  logic        tiro_ack, acerto, afundado, rgb_r, rgb_g, rgb_b;

  int errors = 0;
  int checks = 0;

`ifdef VGA_CONTORNO_EN
  localparam logic [2:0] BRD = 3'b111;
`else
  localparam logic [2:0] BRD = 3'b000;
`endif

  vga_embarcacao_param #(.NCELL(2)) dut (
    .clk(clk), .rst_n(rst_n), .areaAtiva(areaAtiva), .coluna(coluna), .linha(linha),
    .carregar(carregar), .posicoesEmbarcacao(posicoesEmbarcacao),
    .tiro_valido(tiro_valido), .tiro_x(tiro_x), .tiro_y(tiro_y),
    .tiro_ack(tiro_ack), .acerto(acerto), .afundado(afundado),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic [9:0] c;
    logic [9:0] l;
    logic [2:0] exp;
  } vec_t;

  vec_t vt[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic pix(input logic a, input logic [9:0] c, input logic [9:0] l);
    areaAtiva = a;
    coluna    = c;
    linha     = l;
    tick();
  endtask

  task automatic load(input logic [15:0] p);
    posicoesEmbarcacao = p;
    carregar = 1'b1;
    tick();
    carregar = 1'b0;
    tick();
  endtask

  task automatic shot(input string nm, input logic [3:0] x, input logic [3:0] y,
                      input logic exp_hit, input logic exp_af);
    tiro_valido = 1'b1;
    tiro_x = x;
    tiro_y = y;
    tick();
    tiro_valido = 1'b0;
    chk({nm, "_ack_t1"}, tiro_ack, 0);
    tick();
    chk({nm, "_ack_t2"}, tiro_ack, 1);
    chk({nm, "_acerto"}, acerto, exp_hit);
    tick();
    chk({nm, "_ack_t3"}, tiro_ack, 0);
    chk({nm, "_acerto_idle"}, acerto, 0);
    chk({nm, "_afundado"}, afundado, exp_af);
  endtask

  initial begin
    int n;
    vt[0]  = '{1'b1, 10'd40,  10'd40,  3'b001};
    vt[1]  = '{1'b1, 10'd100, 10'd40,  3'b001};
    vt[2]  = '{1'b1, 10'd16,  10'd40,  BRD};
    vt[3]  = '{1'b0, 10'd40,  10'd40,  3'b000};
    vt[4]  = '{1'b1, 10'd17,  10'd17,  3'b001};
    vt[5]  = '{1'b1, 10'd69,  10'd64,  3'b001};
    vt[6]  = '{1'b1, 10'd70,  10'd40,  BRD};
    vt[7]  = '{1'b1, 10'd40,  10'd65,  BRD};
    vt[8]  = '{1'b1, 10'd40,  10'd16,  BRD};
    vt[9]  = '{1'b1, 10'd74,  10'd40,  3'b000};
    vt[10] = '{1'b1, 10'd131, 10'd40,  3'b001};
    vt[11] = '{1'b1, 10'd40,  10'd66,  3'b000};
    vt[12] = '{1'b1, 10'd300, 10'd300, 3'b000};
    vt[13] = '{1'b0, 10'd16,  10'd40,  3'b000};
    vt[14] = '{1'b1, 10'd78,  10'd40,  BRD};

    // reset
    #3 rst_n = 1'b0;
    tick(); tick();
    chk("rst_rgb", {rgb_r, rgb_g, rgb_b}, 3'b000);
    chk("rst_ack", tiro_ack, 0);
    chk("rst_acerto", acerto, 0);
    chk("rst_afundado", afundado, 0);
    rst_n = 1'b1;
    tick();

    pix(1'b1, 10'd40, 10'd40);
    chk("preload_disabled", {rgb_r, rgb_g, rgb_b}, 3'b000);

    // cells (1,1) and (2,1)
    load(16'h1211);
    for (int i = 0; i < 15; i++) begin
      pix(vt[i].a, vt[i].c, vt[i].l);
      chk($sformatf("vec%0d_rgb", i), {rgb_r, rgb_g, rgb_b}, vt[i].exp);
    end
    pix(1'b1, 10'd300, 10'd300);

    shot("miss", 4'd5, 4'd5, 1'b0, 1'b0);
    pix(1'b1, 10'd100, 10'd40);
    chk("miss_mask_unchanged", {rgb_r, rgb_g, rgb_b}, 3'b001);

    shot("hit21", 4'd2, 4'd1, 1'b1, 1'b0);
    pix(1'b1, 10'd100, 10'd40);
    chk("hit_blink0", {rgb_r, rgb_g, rgb_b}, 3'b000);
    pix(1'b1, 10'd40, 10'd40);
    chk("unhit_blue", {rgb_r, rgb_g, rgb_b}, 3'b001);

    for (int k = 1; k <= 16; k++) begin
      pix(1'b1, 10'd0, 10'd0);
      pix(1'b1, 10'd100, 10'd40);
      chk($sformatf("blink_f%0d", k), {rgb_r, rgb_g, rgb_b}, (k % 16 >= 8) ? 3'b100 : 3'b000);
      if (k == 8) begin
        pix(1'b1, 10'd40, 10'd40);
        chk("blink_unhit_blue", {rgb_r, rgb_g, rgb_b}, 3'b001);
      end
    end
    pix(1'b1, 10'd300, 10'd300);

    shot("repeat21", 4'd2, 4'd1, 1'b1, 1'b0);

    // request held across CHECK/RESP yields a single ack
    n = 0;
    tiro_valido = 1'b1; tiro_x = 4'd5; tiro_y = 4'd5;
    tick(); n += int'(tiro_ack);
    tick(); n += int'(tiro_ack);
    tiro_valido = 1'b0;
    tick(); n += int'(tiro_ack);
    tick(); n += int'(tiro_ack);
    chk("held_req_one_ack", n, 1);

    // sink: afundado rises the cycle after the ack
    tiro_valido = 1'b1; tiro_x = 4'd1; tiro_y = 4'd1;
    tick();
    tiro_valido = 1'b0;
    tick();
    chk("sink_ack", tiro_ack, 1);
    chk("sink_acerto", acerto, 1);
    chk("sink_af_not_yet", afundado, 0);
    tick();
    chk("sink_afundado", afundado, 1);
    pix(1'b1, 10'd40, 10'd40);
    chk("sunk_c0_red", {rgb_r, rgb_g, rgb_b}, 3'b100);
    pix(1'b1, 10'd100, 10'd40);
    chk("sunk_c1_red", {rgb_r, rgb_g, rgb_b}, 3'b100);

    // reload clears sunk and hits
    posicoesEmbarcacao = 16'h1211;
    carregar = 1'b1;
    tick();
    carregar = 1'b0;
    chk("reload_af_clear", afundado, 0);
    tick();
    pix(1'b1, 10'd100, 10'd40);
    chk("reload_c1_blue", {rgb_r, rgb_g, rgb_b}, 3'b001);

    // carregar during CHECK aborts the shot
    n = 0;
    tiro_valido = 1'b1; tiro_x = 4'd1; tiro_y = 4'd1;
    tick();
    tiro_valido = 1'b0;
    carregar = 1'b1;
    n += int'(tiro_ack);
    tick();
    carregar = 1'b0;
    n += int'(tiro_ack);
    tick(); n += int'(tiro_ack);
    tick(); n += int'(tiro_ack);
    chk("load_in_check_no_ack", n, 0);
    pix(1'b1, 10'd40, 10'd40);
    chk("load_in_check_no_hit", {rgb_r, rgb_g, rgb_b}, 3'b001);

    // carregar with tiro_valido in IDLE drops the shot
    n = 0;
    tiro_valido = 1'b1; carregar = 1'b1; tiro_x = 4'd1; tiro_y = 4'd1;
    tick();
    tiro_valido = 1'b0; carregar = 1'b0;
    n += int'(tiro_ack);
    tick(); n += int'(tiro_ack);
    tick(); n += int'(tiro_ack);
    chk("load_with_req_dropped", n, 0);

    // cell (0,3) disabled, cell (2,1) alone defines sunk
    load(16'h1230);
    pix(1'b1, 10'd40, 10'd40);
    chk("dis_c0_dark", {rgb_r, rgb_g, rgb_b}, 3'b000);
    pix(1'b1, 10'd100, 10'd40);
    chk("dis_c1_blue", {rgb_r, rgb_g, rgb_b}, 3'b001);
    pix(1'b1, 10'd300, 10'd300);
    shot("dis_shot03", 4'd0, 4'd3, 1'b0, 1'b0);
    shot("dis_shot21", 4'd2, 4'd1, 1'b1, 1'b1);
    pix(1'b1, 10'd100, 10'd40);
    chk("dis_sunk_red", {rgb_r, rgb_g, rgb_b}, 3'b100);

    // async reset mid-CHECK
    tiro_valido = 1'b1; tiro_x = 4'd2; tiro_y = 4'd1;
    tick();
    tiro_valido = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_rgb", {rgb_r, rgb_g, rgb_b}, 3'b000);
    chk("midrst_ack", tiro_ack, 0);
    chk("midrst_afundado", afundado, 0);
    tick();
    rst_n = 1'b1;
    tick();
    shot("postrst", 4'd2, 4'd1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vga_embarcacao_param.md
Name: vga_embarcacao_param

Overview:
Parametrised ship renderer for the 8x8 battleship board on the 640x480 VGA output. It generalises the fixed two-cell cruiser drawer to NCELL cells of any ship class. It also adds registered coordinate decode, a per-cell hit mask with a shot-check handshake, sunk detection, and frame-based blinking of hit cells. One instance sits per ship between the game controller and the VGA colour mux.

Parameters:
NCELL, 2, number of cells in the ship (1..8)
GRID, 8, board size; valid coordinates are 1..GRID
X0, 16, left pixel border of grid column 1
Y0, 16, lower pixel border of grid row 1
PITCH_X, 62, pixel distance between column borders
PITCH_Y, 57, pixel distance between row borders
CELL_W, 54, cell width in pixels
CELL_H, 49, cell height in pixels
BLINK_LOG2, 4, blink half-period is 2^(BLINK_LOG2-1) frames

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
areaAtiva  in  1  high inside the visible area
coluna  in  10  current horizontal pixel
linha  in  10  current vertical pixel
carregar  in  1  one-cycle strobe; latches posicoesEmbarcacao
posicoesEmbarcacao  in  8*NCELL  cell i: X in [8i+3:8i], Y in [8i+7:8i+4]
tiro_valido  in  1  shot request
tiro_x  in  4  shot X coordinate
tiro_y  in  4  shot Y coordinate
tiro_ack  out  1  one-cycle pulse; shot result valid
acerto  out  1  hit result, valid while tiro_ack is high
afundado  out  1  all enabled cells are hit
rgb_r  out  1  red channel
rgb_g  out  1  green channel
rgb_b  out  1  blue channel

Behaviour:
- Reset (async, rst_n=0):
  - all outputs 0
  - position regs 0, so all cells are disabled
  - hit mask 0, FSM IDLE, frame counter 0
- Load:
  - carregar=1 latches positions and clears the hit mask.
  - Borders are registered on the next cycle: left_i=X0+(X-1)*PITCH_X, down_i=Y0+(Y-1)*PITCH_Y, computed 10-bit unsigned.
  - A cell with X or Y equal to 0 or greater than GRID is disabled: it is never drawn and never hit.
- Shot FSM, states IDLE, CHECK, RESP:
  - IDLE: on tiro_valido, latch tiro_x/tiro_y and go to CHECK.
  - CHECK: compare the latched shot against every enabled cell and go to RESP.
  - RESP: tiro_ack=1 for exactly one cycle and acerto=match; set the matching hit bit(s); go to IDLE.
  - Latency: request in cycle T gives tiro_ack in cycle T+2.
  - tiro_valido outside IDLE is ignored.
  - A repeat shot on an already-hit cell returns acerto=1 and leaves the mask unchanged.
  - acerto=0 whenever tiro_ack=0.
- carregar has priority over the FSM. In CHECK or RESP it aborts to IDLE with no ack and no mask update. In IDLE with simultaneous tiro_valido, the shot is dropped.
- afundado is registered: 1 iff at least one cell is enabled and every enabled cell is hit. It updates the cycle after the mask changes; load clears it the next cycle.
- Frame counter (BLINK_LOG2 bits) increments in the cycle where linha==0 and coluna==0. blink = counter MSB.
- Pixel path, registered with 1-cycle latency from coluna/linha to rgb:
  - inside_i = enabled_i && coluna>left_i && coluna<left_i+CELL_W && linha>down_i && linha<down_i+CELL_H (strict inequalities).
  - Colour priority: areaAtiva=0 gives 000. afundado and any inside gives red 100. Inside a hit cell gives 100 when blink=1, else 000. Inside an unhit cell gives blue 001. Otherwise 000.
  - Overlapping cells (duplicate coordinates) OR together; the hit colour wins.

Optional Feature:
VGA_CONTORNO_EN:
- Defined: pixels exactly on a cell's border (coluna==left_i or left_i+CELL_W with linha in range, or linha==down_i or down_i+CELL_H with coluna in range) draw white 111, for enabled cells only, still gated by areaAtiva.
- Undefined: border pixels draw 000, matching the strict-inequality fill.

Test Plan:
- Reset: rst_n=0 mid-CHECK -> rgb=000, tiro_ack=0, afundado=0 immediately; FSM back in IDLE.
- Decode and draw: NCELL=2, load cells (1,1),(2,1); drive coluna=40, linha=40 -> rgb=001 one cycle later. coluna=100, linha=40 -> 001. coluna=16 (border) -> 000. areaAtiva=0 -> 000.
- Miss: tiro (5,5) at T -> tiro_ack=1, acerto=0 at T+2; mask unchanged.
- Hit and blink: tiro (2,1) -> acerto=1 at T+2. Pixel (100,40) toggles 100/000 every 8 frames; pixel (40,40) stays 001.
- Sunk: tiro (1,1) -> acerto=1; afundado=1 the next cycle; both cells steady 100. Reload -> afundado=0, cells blue.
- Edge cases:
  - carregar during CHECK -> no ack.
  - Cell (0,3) -> disabled, never drawn; afundado computed over the remaining cell only.
  - With VGA_CONTORNO_EN, coluna=16, linha=40 -> 111.
